multi_object_collision_tracker: RTL and testbench
=================================================

Name: multi_object_collision_tracker

Overview:
Per-pixel collision tracker between the player sprite and N_OBJ rectangular objects (enemy cars, obstacles, road edges). It runs beside the VGA pixel scan. Each pixel it tests the scan position against every object rectangle and qualifies overlap with the player's draw request. It debounces overlap by a pixel-count threshold, raises one-cycle hit events, and latches a per-frame collision vector at start of frame for the game-logic FSM.

Parameters:
N_OBJ, 4, number of object rectangles tracked
COORD_W, 11, width of pixel coordinates and rectangle geometry (unsigned)
HIT_THRESHOLD, 4, overlapping pixels per object per frame needed to declare a hit (>=1)

Ports:
clk  in  1  pixel clock
resetN  in  1  asynchronous, active-low reset
startOfFrame  in  1  one-cycle pulse at first pixel of each frame
pixel_x  in  COORD_W  current scan column
pixel_y  in  COORD_W  current scan row
player_draw  in  1  player sprite drawing request for current pixel
obj_enable  in  N_OBJ  per-object enable
obj_left  in  N_OBJ*COORD_W  packed, object i at bits [i*COORD_W +: COORD_W]
obj_top  in  N_OBJ*COORD_W  packed, as above
obj_width  in  N_OBJ*COORD_W  packed, as above
obj_height  in  N_OBJ*COORD_W  packed, as above
hit_pulse  out  N_OBJ  one-cycle pulse when object i reaches HIT_THRESHOLD this frame
hit_id  out  $clog2(N_OBJ)  lowest index with hit_pulse set this cycle; 0 if none
frame_hits  out  N_OBJ  sticky hit vector of last completed frame
any_frame_hit  out  1  OR of frame_hits
frame_valid  out  1  high once a full frame has been latched since reset

Behaviour:
- Reset (async, resetN=0): all outputs 0, internal counters and sticky flags 0, pipeline registers 0, FSM -> SYNC.
- Geometry test, combinational on inputs: inside_i = obj_enable[i] & x>=left & x<=left+width-1 & y>=top & y<=top+height-1. Bounds are inclusive on all four edges. Evaluate in COORD_W+1 bits so left+width does not wrap. width==0 or height==0 -> inside_i=0.
- Stage 1 (registered): inside_q[i], draw_q<=player_draw, sof_q<=startOfFrame.
- Stage 2: overlap_i = inside_q[i] & draw_q. Total latency from pixel to hit_pulse is 2 cycles.
- FSM SYNC: ignore overlap, counters held 0, no pulses. On sof_q -> ACTIVE. frame_hits is not loaded on this transition and frame_valid stays 0.
- FSM ACTIVE, per object i, saturating counter cnt_i of width $clog2(HIT_THRESHOLD+1):
  - On overlap_i with cnt_i<HIT_THRESHOLD: cnt_i+1.
  - If cnt_i+1==HIT_THRESHOLD: hit_pulse[i]=1 for that cycle and sticky_i<=1.
  - Further overlaps in the same frame: no pulse, cnt_i holds at HIT_THRESHOLD.
- Frame boundary (sof_q in ACTIVE): frame_hits<=sticky, frame_valid<=1. The pixel on that cycle belongs to the new frame: cnt_i<=overlap_i?1:0 and sticky_i<=(overlap_i & HIT_THRESHOLD==1). A hit pulse is allowed on the sof_q cycle only if HIT_THRESHOLD==1.
- any_frame_hit is registered alongside frame_hits (same cycle).
- hit_pulse and hit_id are registered outputs and change in the same cycle. hit_id uses the lowest-index priority encoder.
- Overlap is not contiguous-required: pixels anywhere in the frame accumulate.
- Geometry inputs may change mid-frame. Each pixel uses the values sampled with it, with no shadowing.
- resetN asserted mid-frame: immediate clear, return to SYNC, first partial frame ignored.
- ACTIVE remains until reset and never returns to SYNC.

Test Plan:
- Reset then sof, obj0 rect left=100,top=50,w=20,h=10, player_draw=1 at (100,50),(119,59),(101,50),(102,50) -> hit_pulse[0] 2 cycles after 4th pixel, hit_id=0; next sof -> frame_hits=0001, any_frame_hit=1, frame_valid=1.
- Edge check, same rect: draw at (99,50),(120,50),(100,49),(100,60) -> no counts. width=0 -> never inside.
- Obj1 and obj3 reach threshold on the same pixel -> hit_pulse=1010, hit_id=1; extra overlapping pixels -> no further pulses in that frame.
- 3 overlaps in frame A, 1 in frame B (threshold 4) -> no hit, frame_hits=0 at both sofs (counter cleared at frame boundary). HIT_THRESHOLD=1 with overlap on the sof pixel -> pulse on that cycle, counted in the new frame.
- Overlap before the first sof after reset -> ignored, frame_valid stays 0 until second sof. resetN pulsed mid-frame after a hit -> all outputs 0 immediately, back to SYNC.
- obj_enable[2]=0 with full overlap -> hit_pulse[2] never set. Enabling mid-frame counts only subsequent pixels.

Source files
------------

// File: rtl/multi_object_collision_tracker.sv
// rtl/multi_object_collision_tracker.sv - per-pixel player/object overlap debounce and per-frame hit latch
module multi_object_collision_tracker #(
    parameter int N_OBJ         = 4,
    parameter int COORD_W       = 11,
    parameter int HIT_THRESHOLD = 4
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic [COORD_W-1:0]         pixel_x,
    input  logic [COORD_W-1:0]         pixel_y,
    input  logic                       player_draw,
    input  logic [N_OBJ-1:0]           obj_enable,
    input  logic [N_OBJ*COORD_W-1:0]   obj_left,
    input  logic [N_OBJ*COORD_W-1:0]   obj_top,
    input  logic [N_OBJ*COORD_W-1:0]   obj_width,
    input  logic [N_OBJ*COORD_W-1:0]   obj_height,
    output logic [N_OBJ-1:0]           hit_pulse,
    output logic [$clog2(N_OBJ)-1:0]   hit_id,
    output logic [N_OBJ-1:0]           frame_hits,
    output logic                       any_frame_hit,
    output logic                       frame_valid
);

    localparam int                ID_W  = $clog2(N_OBJ);
    localparam int                CNT_W = $clog2(HIT_THRESHOLD + 1);
    localparam logic [CNT_W-1:0]  THR   = CNT_W'(HIT_THRESHOLD);

    typedef enum logic {SYNC, ACTIVE} state_t;

    state_t             r_state, w_state_nxt;
    logic [N_OBJ-1:0]   w_inside, r_inside_q, w_overlap;
    logic               r_draw_q, r_sof_q;
    logic [CNT_W-1:0]   r_cnt      [N_OBJ];
    logic [CNT_W-1:0]   w_cnt_nxt  [N_OBJ];
    logic [N_OBJ-1:0]   r_sticky, w_sticky_nxt, w_pulse_nxt;
    logic [ID_W-1:0]    w_id_nxt;
    logic               w_frame_load;

    // Right/bottom bounds are exclusive and one bit wider, so left+width never wraps
    // and a zero width or height gives an empty rectangle.
    for (genvar g = 0; g < N_OBJ; g++) begin : g_geom
        logic [COORD_W-1:0] w_left, w_top, w_width, w_height;
        logic [COORD_W:0]   w_right, w_bottom;
        assign w_left   = obj_left  [g*COORD_W +: COORD_W];
        assign w_top    = obj_top   [g*COORD_W +: COORD_W];
        assign w_width  = obj_width [g*COORD_W +: COORD_W];
        assign w_height = obj_height[g*COORD_W +: COORD_W];
        assign w_right  = {1'b0, w_left} + {1'b0, w_width};
        assign w_bottom = {1'b0, w_top}  + {1'b0, w_height};
        assign w_inside[g] = obj_enable[g]
                           & (pixel_x >= w_left) & ({1'b0, pixel_x} < w_right)
                           & (pixel_y >= w_top)  & ({1'b0, pixel_y} < w_bottom);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_inside_q <= '0;
            r_draw_q   <= 1'b0;
            r_sof_q    <= 1'b0;
        end else begin
            r_inside_q <= w_inside;
            r_draw_q   <= player_draw;
            r_sof_q    <= startOfFrame;
        end
    end

    assign w_overlap = r_inside_q & {N_OBJ{r_draw_q}};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= SYNC;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_frame_load = 1'b0;
        if (r_state == SYNC) begin
            if (r_sof_q) w_state_nxt = ACTIVE;
        end else begin
            w_frame_load = r_sof_q;
        end
    end

    // The pixel on the frame-boundary cycle is the first pixel of the new frame.
    always_comb begin
        w_sticky_nxt = r_sticky;
        w_pulse_nxt  = '0;
        for (int i = 0; i < N_OBJ; i++) w_cnt_nxt[i] = r_cnt[i];
        if (r_state == ACTIVE) begin
            for (int i = 0; i < N_OBJ; i++) begin
                if (r_sof_q) begin
                    w_cnt_nxt[i]    = '0;
                    w_sticky_nxt[i] = 1'b0;
                end
                if (w_overlap[i] && (w_cnt_nxt[i] < THR)) begin
                    w_cnt_nxt[i] = w_cnt_nxt[i] + CNT_W'(1);
                    if (w_cnt_nxt[i] == THR) begin
                        w_pulse_nxt[i]  = 1'b1;
                        w_sticky_nxt[i] = 1'b1;
                    end
                end
            end
        end else begin
            w_sticky_nxt = '0;
            for (int i = 0; i < N_OBJ; i++) w_cnt_nxt[i] = '0;
        end
    end

    always_comb begin
        w_id_nxt = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (w_pulse_nxt[i]) w_id_nxt = ID_W'(i);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < N_OBJ; i++) r_cnt[i] <= '0;
            r_sticky      <= '0;
            hit_pulse     <= '0;
            hit_id        <= '0;
            frame_hits    <= '0;
            any_frame_hit <= 1'b0;
            frame_valid   <= 1'b0;
        end else begin
            for (int i = 0; i < N_OBJ; i++) r_cnt[i] <= w_cnt_nxt[i];
            r_sticky  <= w_sticky_nxt;
            hit_pulse <= w_pulse_nxt;
            hit_id    <= w_id_nxt;
            if (w_frame_load) begin
                frame_hits    <= r_sticky;
                any_frame_hit <= |r_sticky;
                frame_valid   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multi_object_collision_tracker.sv
// tb/tb_multi_object_collision_tracker.sv - vectors, corner sequences and random run against a frame-level model
module tb_multi_object_collision_tracker;
    localparam int N  = 4;
    localparam int CW = 11;

    logic            clk = 1'b0;
    logic            resetN;
    logic            sof, draw;
    logic [CW-1:0]   px, py;
    logic [N-1:0]    en;
    logic [N*CW-1:0] ol, ot, ow, oh;
    logic [N-1:0]    hp4, fh4, hp1, fh1;
    logic [1:0]      id4, id1;
    logic            any4, fv4, any1, fv1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multi_object_collision_tracker u_dut4 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .pixel_x(px), .pixel_y(py),
        .player_draw(draw), .obj_enable(en), .obj_left(ol), .obj_top(ot),
        .obj_width(ow), .obj_height(oh), .hit_pulse(hp4), .hit_id(id4),
        .frame_hits(fh4), .any_frame_hit(any4), .frame_valid(fv4));

    multi_object_collision_tracker #(.HIT_THRESHOLD(1)) u_dut1 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .pixel_x(px), .pixel_y(py),
        .player_draw(draw), .obj_enable(en), .obj_left(ol), .obj_top(ot),
        .obj_width(ow), .obj_height(oh), .hit_pulse(hp1), .hit_id(id1),
        .frame_hits(fh1), .any_frame_hit(any1), .frame_valid(fv1));

    // Frame-level model: index 0 models threshold 4, index 1 threshold 1.
    int           ht_v [2] = '{4, 1};
    int           mcnt [2][N];
    logic [N-1:0] msticky [2], mfh [2], n_pulse [2], e_pulse [2], e_fh [2];
    logic         mstarted, mvalid, e_valid;

    typedef struct {
        bit         sof;
        bit         draw;
        int         x;
        int         y;
        logic [3:0] ep;
        logic [1:0] eid;
        logic [3:0] efh;
        bit         ev;
    } vec_t;
    vec_t tbl [12];

    function automatic logic [1:0] lowest(input logic [N-1:0] v);
        logic [1:0] r = 2'd0;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = 2'(i);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) mcnt[d][i] = 0;
            msticky[d] = '0; mfh[d] = '0; e_pulse[d] = '0; e_fh[d] = '0;
        end
        mstarted = 1'b0; mvalid = 1'b0; e_valid = 1'b0;
    endtask

    task automatic set_obj(input int i, input bit e, input int l, input int t, input int w, input int h);
        en[i]          = e;
        ol[i*CW +: CW] = l[CW-1:0];
        ot[i*CW +: CW] = t[CW-1:0];
        ow[i*CW +: CW] = w[CW-1:0];
        oh[i*CW +: CW] = h[CW-1:0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0; sof = 1'b0; draw = 1'b0; px = '0; py = '0;
        model_clear();
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    // Apply one pixel at the falling edge; outputs seen one clock later belong to the previous pixel.
    task automatic step(input bit s, input bit d, input int x, input int y);
        logic [N-1:0] ins;
        sof = s; draw = d; px = x[CW-1:0]; py = y[CW-1:0];
        for (int i = 0; i < N; i++) begin
            int l = int'(ol[i*CW +: CW]);
            int t = int'(ot[i*CW +: CW]);
            int w = int'(ow[i*CW +: CW]);
            int h = int'(oh[i*CW +: CW]);
            ins[i] = en[i] && x >= l && x <= l + w - 1 && y >= t && y <= t + h - 1;
        end
        for (int k = 0; k < 2; k++) n_pulse[k] = '0;
        if (!mstarted) begin
            if (s) mstarted = 1'b1;
        end else begin
            if (s) begin
                for (int k = 0; k < 2; k++) begin
                    mfh[k] = msticky[k]; msticky[k] = '0;
                    for (int i = 0; i < N; i++) mcnt[k][i] = 0;
                end
                mvalid = 1'b1;
            end
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < N; i++)
                    if (d && ins[i] && mcnt[k][i] < ht_v[k]) begin
                        mcnt[k][i]++;
                        if (mcnt[k][i] == ht_v[k]) begin
                            n_pulse[k][i] = 1'b1; msticky[k][i] = 1'b1;
                        end
                    end
        end
        @(posedge clk);
        @(negedge clk);
        check("model_ht4", {hp4, id4, fh4, any4, fv4},
              {e_pulse[0], lowest(e_pulse[0]), e_fh[0], |e_fh[0], e_valid});
        check("model_ht1", {hp1, id1, fh1, any1, fv1},
              {e_pulse[1], lowest(e_pulse[1]), e_fh[1], |e_fh[1], e_valid});
        for (int k = 0; k < 2; k++) begin
            e_pulse[k] = n_pulse[k]; e_fh[k] = mfh[k];
        end
        e_valid = mvalid;
    endtask

    task automatic rand_obj(input int i);
        bit big_l = ($urandom_range(0, 7) == 0);
        bit big_t = ($urandom_range(0, 7) == 0);
        int l = big_l ? int'($urandom_range(2020, 2047)) : int'($urandom_range(0, 50));
        int t = big_t ? int'($urandom_range(2020, 2047)) : int'($urandom_range(0, 50));
        int w = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 30));
        int h = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 30));
        set_obj(i, $urandom_range(0, 3) != 0, l, t, w, h);
    endtask

    initial begin
        resetN = 1'b0; sof = 1'b0; draw = 1'b0; px = '0; py = '0;
        en = '0; ol = '0; ot = '0; ow = '0; oh = '0;
        model_clear();

        tbl[0]  = '{1, 0,   0,  0, 4'b0000, 2'd0, 4'b0000, 0};
        tbl[1]  = '{0, 1, 100, 50, 4'b0000, 2'd0, 4'b0000, 0};
        tbl[2]  = '{0, 1, 119, 59, 4'b0000, 2'd0, 4'b0000, 0};
        tbl[3]  = '{0, 1, 101, 50, 4'b0000, 2'd0, 4'b0000, 0};
        tbl[4]  = '{0, 1,  99, 50, 4'b0000, 2'd0, 4'b0000, 0};
        tbl[5]  = '{0, 1, 120, 50, 4'b0000, 2'd0, 4'b0000, 0};
        tbl[6]  = '{0, 1, 100, 49, 4'b0000, 2'd0, 4'b0000, 0};
        tbl[7]  = '{0, 1, 100, 60, 4'b0000, 2'd0, 4'b0000, 0};
        tbl[8]  = '{0, 1, 102, 50, 4'b0001, 2'd0, 4'b0000, 0};
        tbl[9]  = '{0, 1, 103, 50, 4'b0000, 2'd0, 4'b0000, 0};
        tbl[10] = '{1, 0,   0,  0, 4'b0000, 2'd0, 4'b0001, 1};
        tbl[11] = '{0, 0, 100, 50, 4'b0000, 2'd0, 4'b0001, 1};

        // Single rectangle: inclusive edges, threshold, saturation, frame latch
        set_obj(0, 1, 100, 50, 20, 10);
        for (int i = 1; i < N; i++) set_obj(i, 0, 0, 0, 0, 0);
        do_reset();
        check("reset_state", {hp4, id4, fh4, any4, fv4}, 32'd0);
        for (int k = 0; k < 12; k++) begin
            step(tbl[k].sof, tbl[k].draw, tbl[k].x, tbl[k].y);
            if (k > 0)
                check($sformatf("tbl_%0d", k - 1), {hp4, id4, fh4, any4, fv4},
                      {tbl[k-1].ep, tbl[k-1].eid, tbl[k-1].efh, |tbl[k-1].efh, tbl[k-1].ev});
        end
        step(0, 0, 0, 0);
        check("tbl_11", {hp4, id4, fh4, any4, fv4},
              {tbl[11].ep, tbl[11].eid, tbl[11].efh, |tbl[11].efh, tbl[11].ev});

        set_obj(0, 1, 100, 50, 0, 10);
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 100, 50);
            check("width0_nopulse", hp4, 32'd0);
        end

        // Two objects reaching threshold on the same pixel; disabled object fully overlapped
        do_reset();
        set_obj(0, 0, 0, 0, 0, 0);
        set_obj(1, 1, 10, 10, 5, 5);
        set_obj(2, 0, 0, 0, 100, 100);
        set_obj(3, 1, 12, 12, 5, 5);
        step(1, 0, 0, 0);
        repeat (4) step(0, 1, 12, 12);
        step(0, 0, 0, 0);
        check("dual_pulse", hp4, 32'b1010);
        check("dual_id", id4, 32'd1);
        repeat (3) step(0, 1, 12, 12);
        step(0, 0, 0, 0);
        check("no_repulse", hp4, 32'd0);
        en[2] = 1'b1;
        repeat (3) step(0, 1, 12, 12);
        step(0, 0, 0, 0);
        check("enable_mid_below", hp4, 32'd0);
        step(0, 1, 12, 12);
        step(0, 0, 0, 0);
        check("enable_mid_pulse", {hp4, id4}, {4'b0100, 2'd2});
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("dual_frame_hits", {fh4, any4, fv4}, {4'b1110, 1'b1, 1'b1});

        // Counters clear at frame boundary; threshold-1 pulse on the boundary pixel
        do_reset();
        en = 4'b0010;
        step(1, 0, 0, 0);
        repeat (3) step(0, 1, 12, 12);
        step(1, 0, 0, 0);
        step(0, 1, 12, 12);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("thr_clear_fh4", {fh4, any4}, 32'd0);
        check("thr_clear_fh1", fh1, 32'b0010);
        step(1, 1, 12, 12);
        step(0, 0, 0, 0);
        check("sof_pulse_ht1", hp1, 32'b0010);
        check("sof_nopulse_ht4", hp4, 32'd0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("sof_counted_new_frame", fh1, 32'b0010);

        // Overlap before first frame start ignored; async reset mid-frame
        do_reset();
        repeat (5) step(0, 1, 12, 12);
        step(0, 0, 0, 0);
        check("pre_sof_ignored", {hp4, fv4}, 32'd0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("first_sof_no_valid", fv4, 32'd0);
        repeat (4) step(0, 1, 12, 12);
        step(0, 0, 0, 0);
        check("post_sof_pulse", hp4, 32'b0010);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("second_sof_valid", {fh4, fv4}, {4'b0010, 1'b1});
        repeat (4) step(0, 1, 12, 12);
        step(0, 0, 0, 0);
        #1 resetN = 1'b0;
        #1;
        check("async_rst_ht4", {hp4, id4, fh4, any4, fv4}, 32'd0);
        check("async_rst_ht1", {hp1, id1, fh1, any1, fv1}, 32'd0);
        model_clear();
        @(negedge clk);
        resetN = 1'b1;
        repeat (3) step(0, 1, 12, 12);
        step(1, 1, 12, 12);
        repeat (4) step(0, 1, 12, 12);
        step(0, 0, 0, 0);

        // Random run with moving geometry
        do_reset();
        for (int i = 0; i < N; i++) rand_obj(i);
        for (int c = 0; c < 3000; c++) begin
            bit bigpix = ($urandom_range(0, 4) == 0);
            int x = bigpix ? int'($urandom_range(2030, 2047)) : int'($urandom_range(0, 63));
            int y = bigpix ? int'($urandom_range(2030, 2047)) : int'($urandom_range(0, 63));
            if ($urandom_range(0, 19) == 0) rand_obj(int'($urandom_range(0, N - 1)));
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, x, y);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
